fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin write arbiter for the shared 32-entry, 8-bit FIFO. Shares the FIFO write port among N
//  producers with a req/gnt handshake: each cycle at most one producer's word passes to the FIFO.
//  Sits between the producer blocks and the FIFO's write/datain/full pins.
// PARAMETERS
//  N      4  number of requesters (2..8)
//  WIDTH  8  data width per requester; must match FIFO datain width
//  BURST  4  max consecutive words per grant; used only when FIFO_ARB_BURST_EN is defined
// PORTS
//  clock        in   1        rising-edge clock
//  reset        in   1        synchronous, active-high reset
//  req          in   N        req[i]=1: requester i holds a valid word on its data slice
//  data         in   N*WIDTH  requester i word on data[i*WIDTH +: WIDTH]
//  gnt          out  N        one-hot; gnt[i]=1: requester i's word is written this cycle
//  fifo_full    in   1        FIFO full flag
//  fifo_write   out  1        FIFO write strobe
//  fifo_datain  out  WIDTH    FIFO write data
//  last_id      out  3        index of the most recently granted requester (registered)
// BEHAVIOUR
//  - Transfer: a word moves in cycle t iff gnt[i]=1 in t. Requester keeps req/data stable until it
//    sees gnt; it may drop req afterwards or keep it high to offer the next word.
//  - gnt is combinational from req, fifo_full and the registered pointer ptr: zero latency.
//    Across all cycles gnt is one-hot or all-zero; gnt=0 whenever fifo_full=1 or req=0.
//  - Priority: search starts at ptr and wraps modulo N (ptr, ptr+1, ..., N-1, 0, ..., ptr-1).
//    The first asserted req wins.
//  - fifo_write = |gnt; fifo_datain = data slice of the granted requester, or 0 when no grant.
//  - Pointer update (no burst): after a transfer by requester k, ptr <= (k+1) mod N.
//    last_id <= k. Both hold when nothing transfers.
//  - Full: with fifo_full=1, no grant and no pointer move. Requests stay pending and are
//    served in normal order when full deasserts.
//  - Simultaneous requests: exactly one winner per cycle; each requester waits at most N-1 transfers.
//  - Request dropped without grant: allowed; no state change.
//  - Reset (any cycle, including mid-burst): ptr=0, last_id=0, burst count=0, lock cleared.
//    While reset=1, gnt=0 and fifo_write=0.
//  - Widths: ptr and last_id are 3 bits; ptr arithmetic wraps at N, not at 8.
// CONFIGURATION
//  FIFO_ARB_BURST_EN defined:
//  - Adds a lock register and a burst counter (0..BURST-1).
//  - After requester k transfers, it stays locked (ptr stays k) while req[k]=1.
//  - The lock releases when k has transferred BURST consecutive words, or when req[k] drops.
//  - On release, ptr <= (k+1) mod N and the counter is cleared.
//  - fifo_full stalls the burst without releasing or counting.
//  FIFO_ARB_BURST_EN undefined:
//  - Lock and counter are absent; BURST is ignored; strict one-word round robin as above.
// TESTING
//  1. After reset: req=4'b1111, data[i]=8'h10+i, fifo_full=0.
//     -> Writes 8'h10,8'h11,8'h12,8'h13,8'h10 on consecutive cycles; gnt cycles 0001,0010,0100,1000.
//  2. ptr=2 (after a grant to requester 1); req=4'b1001.
//     -> gnt=4'b1000 (requester 3 before 0), then gnt=4'b0001.
//  3. req=4'b0110, fifo_full=1 for 3 cycles, then 0.
//     -> gnt=0 and fifo_write=0 for 3 cycles; then requester 1 granted, then requester 2.
//     -> Pointer is unchanged across the stall.
//  4. Assert reset mid-stream with ptr=3.
//     -> Next cycle gnt=0; after release with req=4'b1111, the first grant goes to requester 0.
//  5. FIFO_ARB_BURST_EN, BURST=4, req=4'b0011 steady.
//     -> Requester 0 gets 4 consecutive writes, then requester 1 gets 4.
//     -> If req[0] drops after 2 words, requester 1 is granted the next cycle.
//  6. Chain with the FIFO: 4 requesters push 40 words total, no reads.
//     -> Exactly 32 accepted; full=1; no grant while full; pending words accepted after 8 reads.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port among N producers (zero-latency req/gnt).
// Optional burst locking is compiled in when FIFO_ARB_BURST_EN is defined.
module fifo_wr_arbiter #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] data,
  output logic [N-1:0]       gnt,
  input  logic               fifo_full,
  output logic               fifo_write,
  output logic [WIDTH-1:0]   fifo_datain,
  output logic [2:0]         last_id
);

  logic [2:0] r_ptr;
  logic [2:0] r_last;
  logic       w_found;
  logic       w_xfer;
  logic [2:0] w_win;
  logic [2:0] w_win_next;
  int         w_sel;

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    w_found     = 1'b0;
    w_win       = '0;
    w_sel       = 0;
    gnt         = '0;
    fifo_datain = '0;
    // Visit requesters in order ptr, ptr+1, ... wrapping at N; first asserted req wins.
    for (int off = 0; off < N; off++) begin
      w_sel = (int'(r_ptr) + off >= N) ? int'(r_ptr) + off - N : int'(r_ptr) + off;
      for (int j = 0; j < N; j++) begin
        if (!w_found && req[j] && (j == w_sel)) begin
          w_found = 1'b1;
          w_win   = 3'(j);
        end
      end
    end
    w_xfer = w_found && !reset && !fifo_full;
    for (int j = 0; j < N; j++) begin
      if (w_xfer && (w_win == 3'(j))) begin
        gnt[j]      = 1'b1;
        fifo_datain = data[j*WIDTH +: WIDTH];
      end
    end
    fifo_write = w_xfer;
  end

  assign w_win_next = (w_win == 3'(N-1)) ? 3'd0 : w_win + 3'd1;
  assign last_id    = r_last;

`ifdef FIFO_ARB_BURST_EN
  logic       r_lock;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_cur;
  logic [2:0] w_ptr_inc;
  logic [N-1:0] w_req_rot;

  assign w_req_rot = req >> r_ptr;
  assign w_ptr_inc = (r_ptr == 3'(N-1)) ? 3'd0 : r_ptr + 3'd1;
  // Words already sent in the current burst; a different winner starts a fresh burst.
  assign w_cnt_cur = (r_lock && (w_win == r_ptr)) ? r_cnt : 8'd0;

  // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr  <= '0;
      r_last <= '0;
      r_lock <= 1'b0;
      r_cnt  <= '0;
    end else if (w_xfer) begin
      r_last <= w_win;
      if (w_cnt_cur == 8'(BURST-1)) begin
        r_ptr  <= w_win_next;
        r_lock <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_ptr  <= w_win;
        r_lock <= 1'b1;
        r_cnt  <= w_cnt_cur + 8'd1;
      end
    end else if (r_lock && !w_req_rot[0]) begin
      r_ptr  <= w_ptr_inc;
      r_lock <= 1'b0;
      r_cnt  <= '0;
    end
  end
`else
  // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr  <= '0;
      r_last <= '0;
    end else if (w_xfer) begin
      r_ptr  <= w_win_next;
      r_last <= w_win;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed table, randomized model comparison, FIFO chain.
module tb_fifo_wr_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] data = '0;
  logic [N-1:0]   gnt;
  logic           fifo_full = 1'b0;
  logic           fifo_write;
  logic [W-1:0]   fifo_datain;
  logic [2:0]     last_id;

  int n_vec  = 0;
  int n_miss = 0;

  fifo_wr_arbiter #(.N(N), .WIDTH(W), .BURST(4)) dut (
    .clock(clock), .reset(reset), .req(req), .data(data), .gnt(gnt),
    .fifo_full(fifo_full), .fifo_write(fifo_write), .fifo_datain(fifo_datain),
    .last_id(last_id)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; req = '0; fifo_full = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  typedef struct {
    logic         rst;
    logic [N-1:0] req;
    logic         full;
    logic [N-1:0] gnt;
    logic [W-1:0] dout;
    logic [2:0]   last;
  } vec_t;

  vec_t tbl[16];

  // Reference model state, advanced from the arbitration rules directly.
  int m_ptr, m_last;

  function automatic int model_win(input logic [N-1:0] r);
    for (int off = 0; off < N; off++) begin
      if (r[(m_ptr + off) % N]) return (m_ptr + off) % N;
    end
    return -1;
  endfunction

  initial begin
    tbl[0]  = '{1'b0, 4'b1111, 1'b0, 4'b0001, 8'h10, 3'd0};
    tbl[1]  = '{1'b0, 4'b1111, 1'b0, 4'b0010, 8'h11, 3'd0};
    tbl[2]  = '{1'b0, 4'b1111, 1'b0, 4'b0100, 8'h12, 3'd1};
    tbl[3]  = '{1'b0, 4'b1111, 1'b0, 4'b1000, 8'h13, 3'd2};
    tbl[4]  = '{1'b0, 4'b1111, 1'b0, 4'b0001, 8'h10, 3'd3};
    tbl[5]  = '{1'b0, 4'b1111, 1'b0, 4'b0010, 8'h11, 3'd0};
    tbl[6]  = '{1'b0, 4'b1001, 1'b0, 4'b1000, 8'h13, 3'd1};
    tbl[7]  = '{1'b0, 4'b1001, 1'b0, 4'b0001, 8'h10, 3'd3};
    tbl[8]  = '{1'b0, 4'b0110, 1'b1, 4'b0000, 8'h00, 3'd0};
    tbl[9]  = '{1'b0, 4'b0110, 1'b1, 4'b0000, 8'h00, 3'd0};
    tbl[10] = '{1'b0, 4'b0110, 1'b1, 4'b0000, 8'h00, 3'd0};
    tbl[11] = '{1'b0, 4'b0110, 1'b0, 4'b0010, 8'h11, 3'd0};
    tbl[12] = '{1'b0, 4'b0110, 1'b0, 4'b0100, 8'h12, 3'd1};
    tbl[13] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 8'h00, 3'd2};
    tbl[14] = '{1'b1, 4'b1111, 1'b0, 4'b0000, 8'h00, 3'd2};
    tbl[15] = '{1'b0, 4'b1111, 1'b0, 4'b0001, 8'h10, 3'd0};

    do_reset();

`ifndef FIFO_ARB_BURST_EN
    // Directed table: cycles run back to back from reset.
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      reset = tbl[i].rst; req = tbl[i].req; fifo_full = tbl[i].full;
      data  = {8'h13, 8'h12, 8'h11, 8'h10};
      #1;
      check($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      check($sformatf("tbl%0d_write", i), 32'(fifo_write), 32'(|tbl[i].gnt));
      check($sformatf("tbl%0d_dout", i), 32'(fifo_datain), 32'(tbl[i].dout));
      check($sformatf("tbl%0d_last", i), 32'(last_id), 32'(tbl[i].last));
    end

    // Randomized traffic against the reference model.
    do_reset();
    m_ptr = 0; m_last = 0;
    for (int c = 0; c < 400; c++) begin
      int w;
      logic [N-1:0] eg;
      logic [W-1:0] ed;
      @(negedge clock);
      reset     = ($urandom_range(0, 59) == 0);
      req       = N'($urandom);
      fifo_full = ($urandom_range(0, 3) == 0);
      data      = $urandom;
      #1;
      w  = (reset || fifo_full) ? -1 : model_win(req);
      eg = (w >= 0) ? N'(1 << w) : '0;
      ed = (w >= 0) ? data[w*W +: W] : '0;
      check("rnd_gnt", 32'(gnt), 32'(eg));
      check("rnd_write", 32'(fifo_write), 32'(w >= 0));
      check("rnd_dout", 32'(fifo_datain), 32'(ed));
      check("rnd_last", 32'(last_id), 32'(m_last));
      if (reset) begin
        m_ptr = 0; m_last = 0;
      end else if (w >= 0) begin
        m_last = w; m_ptr = (w + 1) % N;
      end
    end

    // Chain with a 32-deep FIFO model: 40 words offered, 8 reads released late.
    begin
      int sent[N];
      int reads;
      logic [W-1:0] q[$];
      logic [N-1:0] g;
      do_reset();
      for (int i = 0; i < N; i++) sent[i] = 0;
      reads = 0;
      for (int phase = 0; phase < 2; phase++) begin
        for (int c = 0; c < 60; c++) begin
          @(negedge clock);
          if (phase == 1 && reads < 8) begin
            void'(q.pop_front());
            reads++;
          end
          fifo_full = (q.size() >= 32);
          for (int i = 0; i < N; i++) begin
            req[i] = (sent[i] < 10);
            data[i*W +: W] = W'(i*16 + sent[i]);
          end
          #1;
          g = gnt;
          if (fifo_full) check("chain_full_no_gnt", 32'(g), 32'h0);
          for (int i = 0; i < N; i++) begin
            if (g[i]) begin
              q.push_back(data[i*W +: W]);
              sent[i]++;
            end
          end
        end
        check($sformatf("chain_p%0d_depth", phase), 32'(q.size()), 32'd32);
        for (int j = 0; j < 32; j++) begin
          int k;
          k = j + phase * 8;
          if (j < q.size())
            check($sformatf("chain_p%0d_q%0d", phase, j), 32'(q[j]), 32'((k % 4) * 16 + k / 4));
        end
      end
      check("chain_total", 32'(sent[0] + sent[1] + sent[2] + sent[3]), 32'd40);
    end
`else
    // Burst mode: steady req=0011 gives 4 words to 0, then 4 to 1.
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      req = 4'b0011; data = {8'h13, 8'h12, 8'h11, 8'h10};
      #1;
      check($sformatf("burst_gnt%0d", c), 32'(gnt), (c < 4) ? 32'h1 : 32'h2);
    end
    // Requester 0 drops after 2 words; requester 1 takes over immediately.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      req = (c < 2) ? 4'b0011 : 4'b0010;
      #1;
      check($sformatf("burst_drop_gnt%0d", c), 32'(gnt), (c < 2) ? 32'h1 : 32'h2);
    end
    // Full stalls the burst without counting.
    do_reset();
    for (int c = 0; c < 7; c++) begin
      @(negedge clock);
      req = 4'b0011; fifo_full = (c == 2 || c == 3);
      #1;
      check($sformatf("burst_full_gnt%0d", c), 32'(gnt),
            (c == 2 || c == 3) ? 32'h0 : ((c < 6) ? 32'h1 : 32'h2));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
